// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: turns pc changes into records of pc, instruction,
// last register write-back and sequence number, queued in a show-ahead FIFO.
module retire_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          enable,
   input  logic [31:0]   pc,
   input  logic [31:0]   inst,
   input  logic          rf_we,
   input  logic [4:0]    rf_waddr,
   input  logic [31:0]   rf_wdata,
   output logic          trace_valid,
   input  logic          trace_ready,
   output logic [31:0]   trace_pc,
   output logic [31:0]   trace_inst,
   output logic          trace_wb_en,
   output logic [4:0]    trace_wb_addr,
   output logic [31:0]   trace_wb_data,
   output logic [15:0]   trace_seq,
   output logic [AW:0]   count,
   output logic [15:0]   overflow_cnt
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        wb_en;
      logic [4:0]  wb_addr;
      logic [31:0] wb_data;
      logic [15:0] seq;
   } rec_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   rec_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          armed;
   logic [31:0]   prev_pc;
   logic [31:0]   prev_inst;
   logic          pend_en;
   logic [4:0]    pend_addr;
   logic [31:0]   pend_data;
   logic [15:0]   seq;

   logic          cur_wb;
   logic          retire;
   logic          full;
   logic          pop;
   logic          push;
   logic          accept;
   logic          drop;
   rec_t          rec;
   rec_t          head;

   always_comb begin
      cur_wb = rf_we && (rf_waddr != 5'd0);
      retire = armed && (pc != prev_pc);
      full   = (count == FULL);
      pop    = trace_valid && trace_ready;
      push   = retire && enable;
      accept = push && (!full || pop);
      drop   = push && full && !pop;
      // a write landing on the pc-change cycle still belongs to the retiree
      rec.pc      = prev_pc;
      rec.inst    = prev_inst;
      rec.wb_en   = cur_wb || pend_en;
      rec.wb_addr = cur_wb ? rf_waddr : pend_addr;
      rec.wb_data = cur_wb ? rf_wdata : pend_data;
      rec.seq     = seq;
   end

   assign trace_valid = (count != '0);
   assign head        = mem[rd_ptr];

   // outputs read zero while empty so reset state is clean without clearing mem
   assign trace_pc      = trace_valid ? head.pc      : '0;
   assign trace_inst    = trace_valid ? head.inst    : '0;
   assign trace_wb_en   = trace_valid ? head.wb_en   : 1'b0;
   assign trace_wb_addr = trace_valid ? head.wb_addr : '0;
   assign trace_wb_data = trace_valid ? head.wb_data : '0;
   assign trace_seq     = trace_valid ? head.seq     : '0;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         armed     <= 1'b0;
         prev_pc   <= '0;
         prev_inst <= '0;
         pend_en   <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         seq       <= '0;
      end else if (!armed) begin
         armed     <= 1'b1;
         prev_pc   <= pc;
         prev_inst <= inst;
      end else if (retire) begin
         prev_pc   <= pc;
         prev_inst <= inst;
         pend_en   <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         seq       <= seq + 16'd1;
      end else begin
         prev_inst <= inst;
         if (cur_wb) begin
            pend_en   <= 1'b1;
            pend_addr <= rf_waddr;
            pend_data <= rf_wdata;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (accept) mem[wr_ptr] <= rec;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_cnt <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         unique case (1'b1)
            accept && !pop: count <= count + (AW+1)'(1);
            pop && !accept: count <= count - (AW+1)'(1);
            default:        count <= count;
         endcase
         if (drop && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits directly downstream of the CPU core's `pc`/`inst` outputs and register-file write port.
- Detects each instruction retirement, defined as a change of `pc`.
- For each retirement, builds a record: pc, instruction word, last register write-back, sequence number.
- Buffers records in a FIFO with a valid/ready drain port. The consumer is a UART dumper, or the bench for on-line golden-model comparison.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- AW, 4, log2(DEPTH).

Ports:
- clk_in  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = record retirements; 0 = track pc silently, push nothing.
- pc  in  32  current CPU program counter.
- inst  in  32  current CPU instruction word.
- rf_we  in  1  register-file write strobe.
- rf_waddr  in  5  register-file write address.
- rf_wdata  in  32  register-file write data.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts head record.
- trace_pc  out  32  retired instruction address.
- trace_inst  out  32  retired instruction word.
- trace_wb_en  out  1  retired instruction wrote a register other than $0.
- trace_wb_addr  out  5  write-back register.
- trace_wb_data  out  32  write-back value.
- trace_seq  out  16  retirement sequence number.
- count  out  AW+1  FIFO occupancy.
- overflow_cnt  out  16  records dropped because the FIFO was full; saturating.

Behaviour:
- Reset:
  - All outputs 0: trace_valid=0, count=0, overflow_cnt=0, trace_* = 0.
  - Clears armed, prev_pc, prev_inst, wb_pend, seq counter and FIFO pointers.
  - Reset asserted mid-operation discards all buffered records. No partial record survives.
- Tracking register set: prev_pc, prev_inst, armed, and wb_pend (en/addr/data).
- First cycle with reset=0 while armed=0:
  - prev_pc<=pc, prev_inst<=inst, armed<=1.
  - No retire event.
- While armed, each cycle evaluates `retire = (pc != prev_pc)`.
- retire=0:
  - prev_inst<=inst, so the latest instruction word for that pc is kept.
  - If rf_we && rf_waddr!=0: wb_pend<={1, rf_waddr, rf_wdata}. The last write wins.
- retire=1:
  - Record = {prev_pc, prev_inst, wb, seq}.
  - wb = the current-cycle write if rf_we && rf_waddr!=0; otherwise wb_pend.
  - A write in the same cycle as the pc change belongs to the retiring instruction.
  - Then: prev_pc<=pc, prev_inst<=inst, wb_pend<=0, seq<=seq+1 (wraps at 16 bits).
  - The record is pushed only if enable=1.
- Writes to $0 never set wb_en.
- enable=0:
  - Tracking and seq continue.
  - No push, no overflow increment.
- FIFO is first-word-fall-through:
  - trace_valid = (count!=0).
  - trace_* show the head entry.
  - A record pushed at edge N is visible with trace_valid=1 after edge N.
- Pop occurs when trace_valid && trace_ready.
- While trace_valid && !trace_ready, all trace_* are held stable.
- Push while full:
  - Without a same-cycle pop: record dropped; overflow_cnt+1, saturating at 0xFFFF.
  - With a same-cycle pop: push accepted; count unchanged.
- A dropped record still consumes a seq value, so the consumer sees a gap.
- Pointers wrap modulo DEPTH.
- count:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH.
- Pop with count=0 is impossible, since trace_valid=0.
- A push into an empty FIFO with trace_ready=1 appears for at least one cycle before popping.

Test Plan:
- Basic record:
  - Stimulus: reset 2 cycles; pc=0x00400000, inst=0x3c011001 for 3 cycles; rf_we addr 1, data 0x10010000 in cycle 2; then pc=0x00400004; trace_ready=1.
  - Response: one record {pc 0x00400000, inst 0x3c011001, wb_en 1, addr 1, data 0x10010000, seq 0}.
  - count returns to 0.
- $0 and last-write rules:
  - Stimulus: one instruction writes $0=5, then $9=7, then $9=8.
  - Response: wb_en=1, addr 9, data 8.
  - Stimulus: an instruction with only a $0 write.
  - Response: wb_en=0.
- Same-cycle write:
  - Stimulus: rf_we addr 2, data 0xAB asserted in the cycle pc changes.
  - Response: the write is attributed to the retiring record, not to the next one.
- Overflow:
  - Stimulus: trace_ready=0; 20 retirements.
  - Response: count=16, overflow_cnt=4.
  - Then trace_ready=1: 16 records drain with seq 0..15.
  - Then 1 more retirement: seq=20.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full; in one cycle a retirement occurs and trace_ready=1.
  - Response: head popped; new record accepted; count stays 16; overflow_cnt unchanged.
- Backpressure, enable and reset:
  - With trace_ready=0, trace_* are stable for 5 cycles.
  - With enable=0, 3 retirements produce no pushes, but seq advances by 3.
  - Reset with count=7: next cycle count=0, trace_valid=0, overflow_cnt=0.
  - The first retirement after reset has seq 0.
